// File: rtl/demux_1ton_hs.sv
// Registered 1-to-N demultiplexer with valid/ready handshakes, a single-entry
// output stage, per-channel transfer counters and an out-of-range drop pulse.
module demux_1ton_hs #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8,
  parameter int HOLD  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*WIDTH-1:0]   out_data,
  output logic                 drop,
  output logic [N*CNT_W-1:0]   xfer_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

  state_t            state_p0, state_nxt;
  logic [SEL_W-1:0]  sel_p0;
  logic [N-1:0]      vld_p0, vld_nxt;
  logic              drop_p0;
  logic [WIDTH-1:0]  data_p0 [N];
  logic [CNT_W-1:0]  cnt_p0 [N];

  logic sel_rdy;
  logic in_range;
  logic accept;
  logic load;
  logic deliver;

  // Ready of the channel currently owning the stage; other channels are ignored.
  always_comb begin
    sel_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel_p0 == SEL_W'(i)) sel_rdy = out_ready[i];
    end
  end

  assign in_range = ({1'b0, in_sel} < N_L);
  assign in_ready = (state_p0 == EMPTY) || sel_rdy;
  assign accept   = in_valid && in_ready;
  assign load     = accept && in_range;
  assign deliver  = (state_p0 == FULL) && sel_rdy;

  always_comb begin
    state_nxt = state_p0;
    vld_nxt   = vld_p0;
    case (state_p0)
      EMPTY:   if (load) state_nxt = FULL;
      FULL: begin
        if (load)         state_nxt = FULL;
        else if (deliver) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    if (load) begin
      for (int i = 0; i < N; i++) vld_nxt[i] = (in_sel == SEL_W'(i));
    end else if (deliver) begin
      vld_nxt = '0;
    end
  end

  // Stage p0: control registers of the single-entry output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= EMPTY;
      sel_p0   <= '0;
      vld_p0   <= '0;
      drop_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      vld_p0   <= vld_nxt;
      drop_p0  <= accept && !in_range;
      if (load) sel_p0 <= in_sel;
    end
  end

  // Stage p0: per-channel word and completed-transfer counter
  for (genvar i = 0; i < N; i++) begin : g_chan
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_p0[i] <= '0;
        cnt_p0[i]  <= '0;
      end else begin
        if (load && (in_sel == SEL_W'(i)))   data_p0[i] <= in_data;
        if (deliver && (sel_p0 == SEL_W'(i))) cnt_p0[i] <= cnt_p0[i] + CNT_W'(1);
      end
    end

    if (HOLD != 0) begin : g_hold
      assign out_data[i*WIDTH +: WIDTH] = data_p0[i];
    end else begin : g_mask
      assign out_data[i*WIDTH +: WIDTH] = vld_p0[i] ? data_p0[i] : '0;
    end

    assign xfer_cnt[i*CNT_W +: CNT_W] = cnt_p0[i];
  end

  assign out_valid = vld_p0;
  assign drop      = drop_p0;

endmodule

// File: tb/tb_demux_1ton_hs.sv
// Bench for demux_1ton_hs: a default instance (N=4, HOLD=0) and a narrow one
// (N=3, CNT_W=4, HOLD=1) share one stimulus stream and a single-slot reference.
module tb_demux_1ton_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv;
  logic [1:0]  isel;
  logic [7:0]  idata;
  logic [3:0]  ordy;

  logic        a_in_ready, a_drop;
  logic [3:0]  a_out_valid;
  logic [31:0] a_out_data, a_cnt;

  logic        b_in_ready, b_drop;
  logic [2:0]  b_out_valid;
  logic [23:0] b_out_data;
  logic [11:0] b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux_1ton_hs #(.WIDTH(8), .N(4), .SEL_W(2), .CNT_W(8), .HOLD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(a_in_ready), .in_sel(isel),
    .in_data(idata), .out_valid(a_out_valid), .out_ready(ordy), .out_data(a_out_data),
    .drop(a_drop), .xfer_cnt(a_cnt)
  );

  demux_1ton_hs #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(4), .HOLD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(b_in_ready), .in_sel(isel),
    .in_data(idata), .out_valid(b_out_valid), .out_ready(ordy[2:0]), .out_data(b_out_data),
    .drop(b_drop), .xfer_cnt(b_cnt)
  );

  // Reference: one pending word (or none) plus what each channel last received.
  bit          m_full [2];
  int          m_ch   [2];
  logic [7:0]  m_dat  [2][4];
  int          m_cnt  [2][4];
  bit          m_drop [2];
  int          m_n    [2];
  int          m_mod  [2];
  bit          m_hold [2];

  task automatic m_clear();
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 1'b0;
      m_ch[d]   = 0;
      m_drop[d] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_dat[d][i] = 8'h00;
        m_cnt[d][i] = 0;
      end
    end
  endtask

  function automatic bit exp_rdy(int d);
    return !m_full[d] || ordy[m_ch[d]];
  endfunction

  function automatic logic [3:0] exp_valid(int d);
    logic [3:0] r;
    r = '0;
    if (m_full[d]) r[m_ch[d]] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] exp_data(int d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < m_n[d]; i++)
      if (m_hold[d] || (m_full[d] && m_ch[d] == i)) r[i*8 +: 8] = m_dat[d][i];
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt(int d);
    logic [31:0] r;
    logic [31:0] c;
    r = '0;
    for (int i = 0; i < m_n[d]; i++) begin
      c = m_cnt[d][i];
      if (d == 0) r[i*8 +: 8] = c[7:0];
      else        r[i*4 +: 4] = c[3:0];
    end
    return r;
  endfunction

  // Advance the reference by one clock using the inputs now applied, then
  // move to 1 time unit after the rising edge.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      bit dl, rdy, acc;
      int ch;
      ch  = m_ch[d];
      dl  = m_full[d] && ordy[ch];
      rdy = !m_full[d] || ordy[ch];
      acc = iv && rdy;
      if (dl) m_cnt[d][ch] = (m_cnt[d][ch] + 1) % m_mod[d];
      m_drop[d] = acc && (int'(isel) >= m_n[d]);
      if (acc && int'(isel) < m_n[d]) begin
        m_full[d]         = 1'b1;
        m_ch[d]           = int'(isel);
        m_dat[d][int'(isel)] = idata;
      end else if (dl) begin
        m_full[d] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst_n = 1'b0;
    m_clear();
    repeat (cycles) begin
      iv = 1'($urandom); isel = 2'($urandom); idata = 8'($urandom); ordy = 4'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    iv = 1'b0; isel = 2'd0; idata = 8'h00; ordy = 4'hF;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_tests++; if (a_out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_a_valid: got %b want 0000", a_out_valid); end
    n_tests++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_a_data: got %h want 0", a_out_data); end
    n_tests++; if (a_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_a_cnt: got %h want 0", a_cnt); end
    n_tests++; if (a_drop !== 1'b0) begin n_fail++; $display("FAIL reset_a_drop: got %b want 0", a_drop); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready: got %b want 1", a_in_ready); end
    n_tests++; if (b_out_valid !== 3'b000) begin n_fail++; $display("FAIL reset_b_valid: got %b want 000", b_out_valid); end
    n_tests++; if (b_out_data !== 24'h0) begin n_fail++; $display("FAIL reset_b_data: got %h want 0", b_out_data); end
    n_tests++; if (b_cnt !== 12'h0) begin n_fail++; $display("FAIL reset_b_cnt: got %h want 0", b_cnt); end
    release_reset();
    ordy = 4'h0;
    #1;
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", a_in_ready); end
    step();
  endtask

  task automatic test_single();
    iv = 1'b1; isel = 2'd2; idata = 8'hA5; ordy = 4'hF;
    #1;
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", a_in_ready); end
    step();
    iv = 1'b0;
    n_tests++; if (a_out_valid !== 4'b0100) begin n_fail++; $display("FAIL single_valid: got %b want 0100", a_out_valid); end
    n_tests++; if (a_out_data !== 32'h00A5_0000) begin n_fail++; $display("FAIL single_data: got %h want 00a50000", a_out_data); end
    step();
    n_tests++; if (a_cnt[23:16] !== 8'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", a_cnt[23:16]); end
    n_tests++; if (a_out_valid !== 4'b0000) begin n_fail++; $display("FAIL single_valid_clr: got %b want 0000", a_out_valid); end
    n_tests++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL single_data_clr: got %h want 0", a_out_data); end
  endtask

  task automatic test_backpressure();
    iv = 1'b1; isel = 2'd1; idata = 8'h3C; ordy = 4'hF;
    step();
    isel = 2'd0; idata = 8'hFF; ordy = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", k, a_in_ready); end
      n_tests++; if (a_out_data[15:8] !== 8'h3C) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want 3c", k, a_out_data[15:8]); end
      n_tests++; if (a_out_valid !== 4'b0010) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 0010", k, a_out_valid); end
      step();
    end
    ordy = 4'hF;
    #1;
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", a_in_ready); end
    step();
    iv = 1'b0;
    n_tests++; if (a_out_valid !== 4'b0001) begin n_fail++; $display("FAIL bp_swap_valid: got %b want 0001", a_out_valid); end
    n_tests++; if (a_out_data[7:0] !== 8'hFF) begin n_fail++; $display("FAIL bp_swap_data: got %h want ff", a_out_data[7:0]); end
    n_tests++; if (a_cnt[15:8] !== 8'd1) begin n_fail++; $display("FAIL bp_cnt1: got %0d want 1", a_cnt[15:8]); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [5];
    logic [3:0] ev;
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset(1);
    release_reset();
    for (int k = 0; k < 5; k++) begin
      iv = 1'b1; isel = seq[k]; idata = 8'($urandom); ordy = 4'hF;
      #1;
      n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, a_in_ready); end
      step();
      ev = 4'b0001 << seq[k];
      n_tests++; if (a_out_valid !== ev) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", k, a_out_valid, ev); end
      if (k == 3) begin
        n_tests++; if (b_drop !== 1'b1) begin n_fail++; $display("FAIL b2b_b_drop: got %b want 1", b_drop); end
        n_tests++; if (b_out_valid !== 3'b000) begin n_fail++; $display("FAIL b2b_b_valid: got %b want 000", b_out_valid); end
      end
    end
    iv = 1'b0;
    step();
    n_tests++; if (a_cnt !== 32'h0101_0102) begin n_fail++; $display("FAIL b2b_cnt: got %h want 01010102", a_cnt); end
  endtask

  task automatic test_drop();
    logic [31:0] ec, ed;
    iv = 1'b1; isel = 2'd3; idata = 8'h77; ordy = 4'hF;
    step();
    iv = 1'b0;
    ec = exp_cnt(1);
    ed = exp_data(1);
    n_tests++; if (b_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b want 1", b_drop); end
    n_tests++; if (b_out_valid !== 3'b000) begin n_fail++; $display("FAIL drop_valid: got %b want 000", b_out_valid); end
    n_tests++; if (b_cnt !== ec[11:0]) begin n_fail++; $display("FAIL drop_cnt: got %h want %h", b_cnt, ec[11:0]); end
    n_tests++; if (b_out_data !== ed[23:0]) begin n_fail++; $display("FAIL drop_data: got %h want %h", b_out_data, ed[23:0]); end
    step();
    n_tests++; if (b_drop !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle: got %b want 0", b_drop); end
    n_tests++; if (b_out_valid !== 3'b000) begin n_fail++; $display("FAIL drop_valid2: got %b want 000", b_out_valid); end
  endtask

  task automatic test_wrap_hold_reset();
    logic [7:0] last;
    do_reset(1);
    release_reset();
    last = 8'h00;
    for (int k = 0; k < 17; k++) begin
      iv = 1'b1; isel = 2'd0; idata = 8'($urandom); ordy = 4'hF;
      last = idata;
      step();
    end
    iv = 1'b0;
    step();
    n_tests++; if (b_cnt[3:0] !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 1", b_cnt[3:0]); end
    n_tests++; if (a_cnt[7:0] !== 8'd17) begin n_fail++; $display("FAIL wide_cnt: got %0d want 17", a_cnt[7:0]); end
    n_tests++; if (b_out_valid !== 3'b000) begin n_fail++; $display("FAIL hold_valid: got %b want 000", b_out_valid); end
    n_tests++; if (b_out_data[7:0] !== last) begin n_fail++; $display("FAIL hold_data: got %h want %h", b_out_data[7:0], last); end
    n_tests++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL nohold_data: got %h want 0", a_out_data); end
    iv = 1'b1; isel = 2'd0; idata = 8'($urandom); ordy = 4'h0;
    last = idata;
    step();
    iv = 1'b0;
    n_tests++; if (b_out_valid !== 3'b001) begin n_fail++; $display("FAIL pend_valid: got %b want 001", b_out_valid); end
    n_tests++; if (b_out_data[7:0] !== last) begin n_fail++; $display("FAIL pend_data: got %h want %h", b_out_data[7:0], last); end
    rst_n = 1'b0;
    m_clear();
    #1;
    n_tests++; if (b_out_valid !== 3'b000) begin n_fail++; $display("FAIL async_valid: got %b want 000", b_out_valid); end
    n_tests++; if (b_out_data !== 24'h0) begin n_fail++; $display("FAIL async_data: got %h want 0", b_out_data); end
    n_tests++; if (b_cnt !== 12'h0) begin n_fail++; $display("FAIL async_cnt: got %h want 0", b_cnt); end
    n_tests++; if (a_cnt !== 32'h0) begin n_fail++; $display("FAIL async_a_cnt: got %h want 0", a_cnt); end
    @(posedge clk);
    #1;
    release_reset();
    step();
    step();
    n_tests++; if (b_cnt !== 12'h0) begin n_fail++; $display("FAIL lost_word_cnt: got %h want 0", b_cnt); end
    n_tests++; if (b_out_valid !== 3'b000) begin n_fail++; $display("FAIL lost_word_valid: got %b want 000", b_out_valid); end
  endtask

  task automatic test_random();
    logic [3:0]  ev;
    logic [31:0] ed, ec;
    do_reset(2);
    release_reset();
    for (int k = 0; k < 300; k++) begin
      iv    = ($urandom_range(0, 3) != 0);
      isel  = 2'($urandom);
      idata = 8'($urandom);
      for (int b = 0; b < 4; b++) ordy[b] = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++; if (a_in_ready !== exp_rdy(0)) begin n_fail++; $display("FAIL rnd_a_ready[%0d]: got %b want %b", k, a_in_ready, exp_rdy(0)); end
      n_tests++; if (b_in_ready !== exp_rdy(1)) begin n_fail++; $display("FAIL rnd_b_ready[%0d]: got %b want %b", k, b_in_ready, exp_rdy(1)); end
      step();
      ev = exp_valid(0); ed = exp_data(0); ec = exp_cnt(0);
      n_tests++; if (a_out_valid !== ev) begin n_fail++; $display("FAIL rnd_a_valid[%0d]: got %b want %b", k, a_out_valid, ev); end
      n_tests++; if (a_out_data !== ed) begin n_fail++; $display("FAIL rnd_a_data[%0d]: got %h want %h", k, a_out_data, ed); end
      n_tests++; if (a_cnt !== ec) begin n_fail++; $display("FAIL rnd_a_cnt[%0d]: got %h want %h", k, a_cnt, ec); end
      n_tests++; if (a_drop !== m_drop[0]) begin n_fail++; $display("FAIL rnd_a_drop[%0d]: got %b want %b", k, a_drop, m_drop[0]); end
      ev = exp_valid(1); ed = exp_data(1); ec = exp_cnt(1);
      n_tests++; if (b_out_valid !== ev[2:0]) begin n_fail++; $display("FAIL rnd_b_valid[%0d]: got %b want %b", k, b_out_valid, ev[2:0]); end
      n_tests++; if (b_out_data !== ed[23:0]) begin n_fail++; $display("FAIL rnd_b_data[%0d]: got %h want %h", k, b_out_data, ed[23:0]); end
      n_tests++; if (b_cnt !== ec[11:0]) begin n_fail++; $display("FAIL rnd_b_cnt[%0d]: got %h want %h", k, b_cnt, ec[11:0]); end
      n_tests++; if (b_drop !== m_drop[1]) begin n_fail++; $display("FAIL rnd_b_drop[%0d]: got %b want %b", k, b_drop, m_drop[1]); end
    end
    iv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_n    = '{4, 3};
    m_mod  = '{256, 16};
    m_hold = '{1'b0, 1'b1};
    rst_n = 1'b0; iv = 1'b0; isel = 2'd0; idata = 8'h00; ordy = 4'h0;
    m_clear();
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_drop();
    test_wrap_hold_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1ton_hs.md
Name: demux_1toN_hs

Overview:
- Parametrised registered 1-to-N demultiplexer. Next generation of the 4-channel combinational demux.
- Routes one WIDTH-bit input word to one of N output channels.
- Uses a valid/ready handshake on the input and on each output, with a single-entry output stage.
- Adds a per-channel transfer counter and a drop flag for out-of-range selects. Sits between a single producer and N independent consumers.

Parameters:
- WIDTH, 8, data word width in bits
- N, 4, number of output channels (2..16; need not be a power of two)
- SEL_W, 2, select width; must satisfy 2**SEL_W >= N
- CNT_W, 8, width of each per-channel transfer counter
- HOLD, 0, 0 = idle channels drive zero; 1 = idle channels hold their last delivered word

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  block can accept a word this cycle
- in_sel  in  SEL_W  destination channel index
- in_data  in  WIDTH  word to route
- out_valid  out  N  bit i: channel i holds a word
- out_ready  in  N  bit i: consumer i accepts this cycle
- out_data  out  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- drop  out  1  one-cycle pulse: an out-of-range word was consumed
- xfer_cnt  out  N*CNT_W  channel i's completed-transfer count, bits [i*CNT_W +: CNT_W]

Behaviour:
- Interface: one clock (clk), asynchronous active-low reset (rst_n).
- Reset (asynchronous, on rst_n low):
  - stage state EMPTY; out_valid all 0
  - all out_data channel registers 0; xfer_cnt all 0; drop 0
  - in_ready is 1 while in reset and immediately after
- State machine, two states: EMPTY, FULL. Registers: sel_q (SEL_W bits) and one data register per channel.
- Handshake definitions:
  - accept = in_valid && in_ready
  - deliver = FULL && out_ready[sel_q]
- in_ready = EMPTY || out_ready[sel_q]. This is combinational and permits one word per cycle under full throughput.
- Accept with in_sel < N:
  - next cycle: FULL, sel_q = in_sel, data_reg[in_sel] = in_data
  - latency is exactly 1 cycle from accept to out_valid
- Accept with in_sel >= N:
  - the word is discarded and no channel register changes
  - drop = 1 for exactly the following cycle
  - stage goes EMPTY if it delivered this cycle, otherwise it stays unchanged
- FULL with no accept: deliver -> EMPTY; no deliver -> remain FULL.
- Simultaneous deliver and accept in the same cycle: both take effect. The old word counts as delivered and the new word is loaded with no bubble, including when both target the same channel.
- out_valid[i] = FULL && (sel_q == i). At most one bit is set at a time.
- Under backpressure (out_valid[i] && !out_ready[i]), out_data[i], sel_q and out_valid stay stable. in_valid without in_ready has no effect.
- out_data per channel:
  - HOLD=0: out_data[i] = data_reg[i] when out_valid[i], else 0
  - HOLD=1: out_data[i] = data_reg[i] always, i.e. the last word routed to channel i
- xfer_cnt[sel_q] increments by 1 on each deliver and wraps modulo 2**CNT_W silently. Dropped words are not counted.
- out_ready bits of non-selected channels are ignored.
- Reset mid-operation: an in-flight word is lost, not counted, not delivered, and all state clears immediately.
- All outputs except in_ready and the HOLD=0 masking are registered.

Test Plan:
- Reset (N=4, WIDTH=8):
  - stimulus: hold rst_n=0 for 3 cycles with random inputs
  - required: out_valid=4'b0000, out_data=0, xfer_cnt=0, drop=0, in_ready=1
- Single transfer:
  - stimulus: in_sel=2, in_data=8'hA5, in_valid=1 for one cycle; out_ready=4'b1111
  - required: next cycle out_valid=4'b0100, out_data[2]=8'hA5, all other channels 0; one cycle later xfer_cnt[2]=1 and out_valid=0
- Backpressure:
  - stimulus: load sel=1, data=8'h3C; hold out_ready[1]=0 for 5 cycles while in_valid=1, sel=0, data=8'hFF
  - required: in_ready=0 and out_data[1]=8'h3C stable for all 5 cycles
  - then: raising out_ready[1] delivers 8'h3C and loads 8'hFF to channel 0 in the same cycle
- Back-to-back:
  - stimulus: sels 0,1,2,3,0 on consecutive cycles, all out_ready=1
  - required: in_ready stays 1, out_valid walks 0001,0010,0100,1000,0001, final xfer_cnt = {1,1,1,2}
- Drop (N=3, SEL_W=2):
  - stimulus: accept sel=3, data=8'h77
  - required: drop=1 for exactly one cycle, out_valid stays 000, no xfer_cnt changes
- Wrap, HOLD and reset (CNT_W=4, HOLD=1):
  - stimulus: 17 transfers to channel 0
  - required: xfer_cnt[0]=1, and out_data[0] keeps the last word after out_valid drops
  - stimulus: assert rst_n=0 while FULL
  - required: immediate clear, and the pending word is never counted
